// File: rtl/wb_trace_buf_pkg.sv
// -----------------------------------------------------------------------------
// wb_trace_buf_pkg
// Shared definitions for the write-back trace buffer:
//   - field widths of one trace entry (PC, destination register, data)
//   - the register-zero constant (writes to $0 are never traced)
//   - the packed trace entry type and the capture-filter helper
// -----------------------------------------------------------------------------
package wb_trace_buf_pkg;

  localparam int PC_W    = 32;
  localparam int ADDR_W  = 5;
  localparam int DATA_W  = 32;
  localparam int ENTRY_W = PC_W + ADDR_W + DATA_W;

  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } trace_entry_t;

  // A write-back is worth tracing only when it really changes architectural
  // state; $0 is hardwired to zero so its writes carry no information.
  function automatic logic is_capture(input logic en, input logic [ADDR_W-1:0] addr);
    return en && (addr != REG_ZERO);
  endfunction

endpackage

// File: rtl/wb_trace_fifo.sv
// -----------------------------------------------------------------------------
// wb_trace_fifo
// Synchronous FIFO with a registered head entry.
// Ports:
//   clk, reset  - single clock, synchronous active-high reset
//   push, din   - write request and data (ignored when full without a pop)
//   pop_req     - consumer ready; a pop happens when valid && pop_req
//   valid, dout - head entry present / head entry (all zeros when empty)
//   level       - exact occupancy 0..DEPTH
// The head is a dedicated register loaded one cycle after the entry is pushed,
// so the input never reaches dout combinationally.
// -----------------------------------------------------------------------------
module wb_trace_fifo
  import wb_trace_buf_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int W     = ENTRY_W,
  localparam int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [W-1:0]     din,
  input  logic             pop_req,
  output logic             valid,
  output logic [W-1:0]     dout,
  output logic [LVL_W-1:0] level
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]     mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W-1:0] rd_next_s;
  logic [LVL_W-1:0] count_r;
  logic [LVL_W-1:0] count_next_s;
  logic [W-1:0]     head_r;
  logic [W-1:0]     head_next_s;
  logic             valid_r;
  logic             push_s;
  logic             pop_s;
  logic             full_s;

  // Next-state computation: occupancy and the entry that will sit at the head.
  always_comb begin
    full_s    = (count_r == LVL_W'(DEPTH));
    pop_s     = pop_req & valid_r;
    // A full FIFO can still take a push when the head leaves this cycle.
    push_s    = push & (~full_s | pop_s);
    rd_next_s = rd_ptr_r + PTR_W'(1);

    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + LVL_W'(1);
      2'b01:   count_next_s = count_r - LVL_W'(1);
      default: count_next_s = count_r;
    endcase

    // Head after this edge: the next stored entry when popping, the incoming
    // entry when it becomes the only one, otherwise the current head. Zero
    // when nothing is left so the outputs never show stale data.
    if (count_next_s == LVL_W'(0)) begin
      head_next_s = {W{1'b0}};
    end else if (pop_s) begin
      if (count_r > LVL_W'(1)) begin
        head_next_s = mem_r[rd_next_s];
      end else begin
        head_next_s = din;
      end
    end else if (count_r == LVL_W'(0)) begin
      head_next_s = din;
    end else begin
      head_next_s = head_r;
    end
  end

  // Storage, pointers, occupancy and head register.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {W{1'b0}};
      end
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {LVL_W{1'b0}};
      head_r   <= {W{1'b0}};
      valid_r  <= 1'b0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= din;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_next_s;
      end
      count_r <= count_next_s;
      head_r  <= head_next_s;
      valid_r <= (count_next_s != LVL_W'(0));
    end
  end

  assign valid = valid_r;
  assign dout  = head_r;
  assign level = count_r;

endmodule

// File: rtl/wb_trace_buf.sv
// -----------------------------------------------------------------------------
// wb_trace_buf
// Trace buffer for register-file write-backs.
// Ports:
//   clk, reset                  - single clock, synchronous active-high reset
//   wb_en, wb_pc, wb_addr, wb_data - write-back stage event
//   out_valid, out_ready        - head entry handshake (pop on valid && ready)
//   out_pc, out_addr, out_data  - head entry fields (zero while out_valid=0)
//   out_seq                     - sequence number of the head entry
//   level                       - current occupancy
//   overflow                    - sticky: at least one event was dropped
//   drop_cnt                    - saturating count of dropped events
// Writes to $0 are filtered out. Events arriving while full and not popping
// are dropped and do not consume a sequence number.
// -----------------------------------------------------------------------------
module wb_trace_buf
  import wb_trace_buf_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wb_en,
  input  logic [PC_W-1:0]          wb_pc,
  input  logic [ADDR_W-1:0]        wb_addr,
  input  logic [DATA_W-1:0]        wb_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [PC_W-1:0]          out_pc,
  output logic [ADDR_W-1:0]        out_addr,
  output logic [DATA_W-1:0]        out_data,
  output logic [CNT_W-1:0]         out_seq,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [CNT_W-1:0]         drop_cnt
);

  localparam int LVL_W  = $clog2(DEPTH) + 1;
  localparam int FIFO_W = CNT_W + ENTRY_W;

  logic              capture_s;
  logic              pop_s;
  logic              full_s;
  logic              store_s;
  logic              drop_s;
  logic [CNT_W-1:0]  seq_r;
  logic [CNT_W-1:0]  drop_cnt_r;
  logic              overflow_r;
  logic [FIFO_W-1:0] fifo_din_s;
  logic [FIFO_W-1:0] fifo_dout_s;
  logic              fifo_valid_s;
  logic [LVL_W-1:0]  fifo_level_s;
  trace_entry_t      head_s;

  // Capture filter and store/drop decision; the entry is tagged with the
  // current sequence number on its way into the FIFO.
  always_comb begin
    capture_s  = is_capture(wb_en, wb_addr);
    pop_s      = fifo_valid_s & out_ready;
    full_s     = (fifo_level_s == LVL_W'(DEPTH));
    store_s    = capture_s & (~full_s | pop_s);
    drop_s     = capture_s & full_s & ~pop_s;
    fifo_din_s = {seq_r, wb_pc, wb_addr, wb_data};
  end

  // Sequence counter, sticky overflow flag and saturating drop counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      seq_r      <= {CNT_W{1'b0}};
      overflow_r <= 1'b0;
      drop_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (store_s) begin
        seq_r <= seq_r + CNT_W'(1);
      end
      if (drop_s) begin
        overflow_r <= 1'b1;
      end
      if (drop_s && (drop_cnt_r != {CNT_W{1'b1}})) begin
        drop_cnt_r <= drop_cnt_r + CNT_W'(1);
      end
    end
  end

  wb_trace_fifo #(
    .DEPTH (DEPTH),
    .W     (FIFO_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (store_s),
    .din     (fifo_din_s),
    .pop_req (out_ready),
    .valid   (fifo_valid_s),
    .dout    (fifo_dout_s),
    .level   (fifo_level_s)
  );

  assign head_s    = trace_entry_t'(fifo_dout_s[ENTRY_W-1:0]);
  assign out_valid = fifo_valid_s;
  assign out_pc    = head_s.pc;
  assign out_addr  = head_s.addr;
  assign out_data  = head_s.data;
  assign out_seq   = fifo_dout_s[FIFO_W-1 -: CNT_W];
  assign level     = fifo_level_s;
  assign overflow  = overflow_r;
  assign drop_cnt  = drop_cnt_r;

endmodule

// File: tb/tb_wb_trace_buf.sv
// -----------------------------------------------------------------------------
// tb_wb_trace_buf
// Directed stimulus with a scoreboard: the stimulus process pushes the expected
// entry for every capture it knows will be stored; a negedge monitor pops and
// compares on every handshake, checks head stability under back-pressure and
// zeroed outputs while empty.
// -----------------------------------------------------------------------------
module tb_wb_trace_buf;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [15:0] seq;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        wb_en;
  logic [31:0] wb_pc;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [4:0]  out_addr;
  logic [31:0] out_data;
  logic [15:0] out_seq;
  logic [3:0]  level;
  logic        overflow;
  logic [15:0] drop_cnt;

  int   n_cmp  = 0;
  int   n_fail = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  logic [15:0] exp_seq;
  logic        saw_wrap = 1'b0;
  logic [15:0] last_seq = 16'd0;

  logic        prev_reset = 1'b1;
  logic        prev_valid = 1'b0;
  logic        prev_ready = 1'b0;
  logic [31:0] prev_pc    = 32'd0;
  logic [4:0]  prev_addr  = 5'd0;
  logic [31:0] prev_data  = 32'd0;
  logic [15:0] prev_seq   = 16'd0;

  wb_trace_buf #(.DEPTH(8), .CNT_W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .wb_en     (wb_en),
    .wb_pc     (wb_pc),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_addr  (out_addr),
    .out_data  (out_data),
    .out_seq   (out_seq),
    .level     (level),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] pc, input logic [4:0] addr,
                              input logic [31:0] data, input logic [15:0] seq);
    exp_t e;
    e.pc = pc; e.addr = addr; e.data = data; e.seq = seq;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic [31:0] pc, input logic [4:0] addr,
                       input logic [31:0] data);
    wb_en = en; wb_pc = pc; wb_addr = addr; wb_data = data;
  endtask

  task automatic wait_empty(input int budget);
    int k;
    k = 0;
    while (level != 4'd0 && k < budget) begin
      tick();
      k++;
    end
    chk("drain_level", 32'(level), 32'd0);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // Scoreboard monitor: sampled on the falling edge, away from state updates.
  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL sb_unexpected: pop of seq 0x%0h, expected no entry", out_seq);
        end else begin
          mon_e = exp_q.pop_front();
          chk("sb_pc",   out_pc,         mon_e.pc);
          chk("sb_addr", 32'(out_addr),  32'(mon_e.addr));
          chk("sb_data", out_data,       mon_e.data);
          chk("sb_seq",  32'(out_seq),   32'(mon_e.seq));
          if (last_seq == 16'hFFFF && out_seq == 16'h0000) saw_wrap = 1'b1;
          last_seq = out_seq;
        end
      end
      if (!out_valid) begin
        chk("idle_zero", 32'(|{out_pc, out_addr, out_data, out_seq}), 32'd0);
      end
      if (!prev_reset && prev_valid && !prev_ready) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_pc",    out_pc,         prev_pc);
        chk("hold_addr",  32'(out_addr),  32'(prev_addr));
        chk("hold_data",  out_data,       prev_data);
        chk("hold_seq",   32'(out_seq),   32'(prev_seq));
      end
    end
    prev_reset = reset;
    prev_valid = out_valid;
    prev_ready = out_ready;
    prev_pc    = out_pc;
    prev_addr  = out_addr;
    prev_data  = out_data;
    prev_seq   = out_seq;
  end

  initial begin
    reset = 1'b1; out_ready = 1'b0;
    drive(1'b0, 32'd0, 5'd0, 32'd0);
    exp_seq = 16'd0;
    tick();
    chk("rst_level",    32'(level),     32'd0);
    chk("rst_valid",    32'(out_valid), 32'd0);
    chk("rst_overflow", 32'(overflow),  32'd0);
    chk("rst_drop",     32'(drop_cnt),  32'd0);
    chk("rst_pc",       out_pc,         32'd0);
    reset = 1'b0;

    // Writes to $0 are ignored.
    drive(1'b1, 32'hDEAD, 5'd0, 32'h55);
    repeat (5) tick();
    drive(1'b0, 32'd0, 5'd0, 32'd0);
    chk("zero_level", 32'(level),     32'd0);
    chk("zero_valid", 32'(out_valid), 32'd0);
    chk("zero_drop",  32'(drop_cnt),  32'd0);

    // Single capture, held under back-pressure, then accepted.
    drive(1'b1, 32'h3000, 5'd8, 32'h1234);
    exp_q.push_back(mk(32'h3000, 5'd8, 32'h1234, exp_seq));
    exp_seq = exp_seq + 16'd1;
    tick();
    drive(1'b0, 32'd0, 5'd0, 32'd0);
    chk("one_valid", 32'(out_valid), 32'd1);
    chk("one_pc",    out_pc,         32'h3000);
    chk("one_addr",  32'(out_addr),  32'd8);
    chk("one_data",  out_data,       32'h1234);
    chk("one_seq",   32'(out_seq),   32'd0);
    repeat (4) tick();
    chk("one_still_pc", out_pc, 32'h3000);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("one_pop_level", 32'(level),     32'd0);
    chk("one_pop_valid", 32'(out_valid), 32'd0);

    // Fill past capacity: 8 stored, 2 dropped.
    reset = 1'b1; exp_q.delete(); exp_seq = 16'd0;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'h100 + 32'(i * 4), 5'(i + 1), 32'hA000 + 32'(i));
      if (i < 8) begin
        exp_q.push_back(mk(32'h100 + 32'(i * 4), 5'(i + 1), 32'hA000 + 32'(i), exp_seq));
        exp_seq = exp_seq + 16'd1;
      end
      tick();
    end
    drive(1'b0, 32'd0, 5'd0, 32'd0);
    chk("full_level",    32'(level),    32'd8);
    chk("full_overflow", 32'(overflow), 32'd1);
    chk("full_drop",     32'(drop_cnt), 32'd2);
    chk("full_head_seq", 32'(out_seq),  32'd0);
    // $0 write while full is neither stored nor a drop.
    drive(1'b1, 32'h180, 5'd0, 32'hFFFF);
    tick();
    drive(1'b0, 32'd0, 5'd0, 32'd0);
    chk("full_zero_drop",  32'(drop_cnt), 32'd2);
    chk("full_zero_level", 32'(level),    32'd8);

    // Capture at full with a same-cycle pop is accepted.
    out_ready = 1'b1;
    drive(1'b1, 32'h200, 5'd3, 32'hBEEF);
    exp_q.push_back(mk(32'h200, 5'd3, 32'hBEEF, exp_seq));
    exp_seq = exp_seq + 16'd1;
    tick();
    drive(1'b0, 32'd0, 5'd0, 32'd0);
    out_ready = 1'b0;
    chk("fullpop_level", 32'(level),    32'd8);
    chk("fullpop_drop",  32'(drop_cnt), 32'd2);
    chk("fullpop_seq",   32'(out_seq),  32'd1);
    out_ready = 1'b1;
    wait_empty(20);
    out_ready = 1'b0;

    // Reset mid-operation with a coincident capture and pop.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h400 + 32'(i * 4), 5'(10 + i), 32'hC000 + 32'(i));
      exp_q.push_back(mk(32'h400 + 32'(i * 4), 5'(10 + i), 32'hC000 + 32'(i), exp_seq));
      exp_seq = exp_seq + 16'd1;
      tick();
    end
    drive(1'b0, 32'd0, 5'd0, 32'd0);
    chk("mid_level",    32'(level),    32'd5);
    chk("mid_overflow", 32'(overflow), 32'd1);
    reset = 1'b1; out_ready = 1'b1;
    drive(1'b1, 32'h999, 5'd7, 32'h777);
    exp_q.delete();
    tick();
    reset = 1'b0; out_ready = 1'b0;
    drive(1'b0, 32'd0, 5'd0, 32'd0);
    exp_seq = 16'd0;
    chk("mrst_level",    32'(level),     32'd0);
    chk("mrst_valid",    32'(out_valid), 32'd0);
    chk("mrst_overflow", 32'(overflow),  32'd0);
    chk("mrst_drop",     32'(drop_cnt),  32'd0);
    drive(1'b1, 32'h500, 5'd9, 32'h42);
    exp_q.push_back(mk(32'h500, 5'd9, 32'h42, exp_seq));
    exp_seq = exp_seq + 16'd1;
    tick();
    drive(1'b0, 32'd0, 5'd0, 32'd0);
    chk("mrst_seq",   32'(out_seq), 32'd0);
    chk("mrst_pc",    out_pc,       32'h500);
    chk("mrst_level", 32'(level),   32'd1);
    out_ready = 1'b1;
    wait_empty(4);

    // Streaming through the sequence-number wrap.
    reset = 1'b1; exp_q.delete();
    tick();
    reset = 1'b0; exp_seq = 16'd0;
    out_ready = 1'b1;
    for (int i = 0; i < 65540; i++) begin
      drive(1'b1, 32'(i), 5'((i % 31) + 1), ~32'(i));
      exp_q.push_back(mk(32'(i), 5'((i % 31) + 1), ~32'(i), exp_seq));
      exp_seq = exp_seq + 16'd1;
      tick();
    end
    drive(1'b0, 32'd0, 5'd0, 32'd0);
    wait_empty(10);
    out_ready = 1'b0;
    chk("wrap_seen",     32'(saw_wrap), 32'd1);
    chk("wrap_drop",     32'(drop_cnt), 32'd0);
    chk("wrap_overflow", 32'(overflow), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_trace_buf.md
WB_TRACE_BUF -- requirements
Module: wb_trace_buf

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, meaning trace entries held (power of two, 2..64).
REQ-002 The block SHALL have parameter CNT_W, default 16, meaning width of the drop and sequence counters.
REQ-003 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 The block SHALL have port wb_en  input  1  the pipeline write-back stage writes the register file this cycle.
REQ-006 The block SHALL have port wb_pc  input  32  PC of the write-back instruction.
REQ-007 The block SHALL have port wb_addr  input  5  destination register number.
REQ-008 The block SHALL have port wb_data  input  32  value written.
REQ-009 The block SHALL have port out_valid  output  1  head entry available.
REQ-010 The block SHALL have port out_ready  input  1  consumer accepts the head entry.
REQ-011 The block SHALL have port out_pc, out_addr, out_data  output  32/5/32  head entry fields.
REQ-012 The block SHALL have port out_seq  output  CNT_W  sequence number of the head entry.
REQ-013 The block SHALL have port level  output  log2(DEPTH)+1  current occupancy.
REQ-014 The block SHALL have port overflow  output  1  sticky flag: at least one event dropped.
REQ-015 The block SHALL have port drop_cnt  output  CNT_W  number of dropped events.

Function
REQ-016 Capture event SHALL be defined as wb_en=1 and wb_addr!=0; writes to $0 SHALL be ignored (not stored, not counted as drops).
REQ-017 A pop SHALL occur in any cycle where out_valid=1 and out_ready=1.
REQ-018 A capture event SHALL be stored when level<DEPTH, or when level=DEPTH and a pop occurs the same cycle.
REQ-019 Stored entries SHALL become visible at the head one cycle after capture (out_valid rises the cycle after the first push into an empty buffer).
REQ-020 The block SHALL NOT bypass a capture event to the outputs combinationally, including when empty.
REQ-021 The head outputs SHALL remain stable while out_valid=1 and out_ready=0.
REQ-022 Entries SHALL be delivered in capture order.
REQ-023 With a simultaneous push and pop, level SHALL be unchanged.
REQ-024 A pop at level 0 is impossible (out_valid=0) and SHALL NOT change state.
REQ-025 Each stored entry SHALL be tagged with a sequence counter that starts at 0 and increments by 1 per stored entry, wrapping modulo 2^CNT_W.
REQ-026 Dropped events SHALL NOT consume a sequence number.
REQ-027 A capture event arriving at level=DEPTH without a same-cycle pop SHALL be dropped.
REQ-028 On a drop, overflow SHALL be set to 1 and drop_cnt SHALL increment, saturating at 2^CNT_W-1.
REQ-029 Read and write pointers SHALL wrap modulo DEPTH; level SHALL be the exact occupancy 0..DEPTH.
REQ-030 The block SHALL store no X-derived data; out_* SHALL be 0 while out_valid=0.

Reset
REQ-031 On reset=1 at a clock edge, level, pointers and the sequence counter SHALL be set to 0, overflow to 0, drop_cnt to 0 and out_valid to 0; all out_* SHALL read 0.
REQ-032 Reset SHALL have priority over simultaneous capture and pop, and buffered entries SHALL be discarded when reset occurs mid-operation.
REQ-033 A capture event coincident with the reset edge SHALL NOT be recorded.

Structure
REQ-034 A shared package SHALL hold the trace entry field widths (PC 32, register address 5, data 32) and the register-zero constant.
REQ-035 The storage SHALL be one sub-module, wb_trace_fifo, a synchronous FIFO with registered head.
REQ-036 The top level SHALL contain the filter logic, the sequence counter, and the drop/overflow logic.

Verification
REQ-037 The bench SHALL cover reset pulse then wb_en=1, wb_addr=0 for 5 cycles -> level=0, out_valid=0, drop_cnt=0.
REQ-038 The bench SHALL cover a single capture (pc=0x3000, addr=8, data=0x1234) with out_ready=0 -> out_valid=1 the next cycle with those fields and out_seq=0, held stable for 4 cycles; then out_ready=1 -> level=0 one cycle later.
REQ-039 The bench SHALL cover 10 back-to-back captures with DEPTH=8 and out_ready=0 -> level=8, overflow=1, drop_cnt=2; draining yields seq 0..7 in order.
REQ-040 The bench SHALL cover a capture at level=8 while out_ready=1 -> entry accepted, level stays 8, drop_cnt unchanged.
REQ-041 The bench SHALL cover reset asserted at level=5 with overflow=1 -> next cycle level=0, out_valid=0, overflow=0, drop_cnt=0, and the next stored entry has out_seq=0.
REQ-042 The bench SHALL cover 65540 accepted entries with continuous out_ready=1 -> out_seq wraps from 0xFFFF to 0, no drops.
